// File: rtl/plic_gateway.sv
// Per-source PLIC interrupt gateway: level/edge triggering, edge burst counting, claim/complete hold-off.
// Optional build macro PLIC_GATEWAY_SYNC_EN inserts a two-flop synchronizer on irq_i.
module plic_gateway #(
  parameter int unsigned IRQ_NUM   = 32,
  parameter int unsigned IRQ_WIDTH = 5,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         en_i,
  input  logic [IRQ_NUM-1:0]           tm_i,
  input  logic [CNT_WIDTH-1:0]         tnm_i,
  input  logic [IRQ_NUM-1:0]           irq_i,
  input  logic                         clam_i,
  input  logic                         comp_i,
  input  logic [IRQ_WIDTH-1:0]         id_i,
  output logic [IRQ_NUM-1:0]           req_o,
  output logic [IRQ_NUM-1:0]           busy_o,
  output logic [IRQ_NUM*CNT_WIDTH-1:0] cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    BUSY = 2'd2
  } state_e;

  state_e                              state_q [IRQ_NUM];
  state_e                              state_d [IRQ_NUM];
  logic [IRQ_NUM-1:0][CNT_WIDTH-1:0]   cnt_q;
  logic [IRQ_NUM-1:0][CNT_WIDTH-1:0]   cnt_d;
  logic [IRQ_NUM-1:0]                  s_irq;
  logic [IRQ_NUM-1:0]                  irq_prev_q;
  logic [IRQ_NUM-1:0]                  rise;
  logic [IRQ_NUM-1:0]                  req_d;
  logic [IRQ_NUM-1:0]                  busy_d;
  logic [CNT_WIDTH-1:0]                lim;

`ifdef PLIC_GATEWAY_SYNC_EN
  logic [IRQ_NUM-1:0] sync1_q;
  logic [IRQ_NUM-1:0] sync2_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign s_irq = sync2_q;
`else
  assign s_irq = irq_i;
`endif

  assign rise  = s_irq & ~irq_prev_q;
  // A programmed limit of zero still allows one buffered edge.
  assign lim   = (tnm_i == '0) ? CNT_WIDTH'(1) : tnm_i;
  assign cnt_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < IRQ_NUM; i++) state_q[i] <= IDLE;
      cnt_q      <= '0;
      irq_prev_q <= '0;
      req_o      <= '0;
      busy_o     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      irq_prev_q <= s_irq;
      req_o      <= req_d;
      busy_o     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = '0;
    busy_d  = '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      unique case (state_q[i])
        IDLE: if (en_i && (tm_i[i] ? (rise[i] || (cnt_q[i] != '0)) : s_irq[i])) state_d[i] = PEND;
        PEND: if (clam_i && (id_i == IRQ_WIDTH'(i))) state_d[i] = BUSY;
        BUSY: if (comp_i && (id_i == IRQ_WIDTH'(i))) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase

      // Edges while claimed/pending are buffered; an edge-less IDLE exit consumes one.
      if (!tm_i[i]) begin
        cnt_d[i] = '0;
      end else if (en_i && rise[i] && (state_q[i] != IDLE)) begin
        if (cnt_q[i] < lim) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end else if (en_i && !rise[i] && (state_q[i] == IDLE) && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
      end
    end

    // Source 0 is reserved and never requests.
    state_d[0] = IDLE;
    cnt_d[0]   = '0;

    for (int i = 0; i < IRQ_NUM; i++) begin
      req_d[i]  = (state_d[i] == PEND);
      busy_d[i] = (state_d[i] == BUSY);
    end
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Self-checking bench for plic_gateway: directed scenarios plus random traffic against a rule-level model.
module tb_plic_gateway;

  localparam int unsigned IRQ_NUM   = 32;
  localparam int unsigned IRQ_WIDTH = 5;
  localparam int unsigned CNT_WIDTH = 4;
  localparam int S_IDLE = 0;
  localparam int S_PEND = 1;
  localparam int S_BUSY = 2;

  logic                         clk = 1'b0;
  logic                         rst_n_i;
  logic                         en_i;
  logic [IRQ_NUM-1:0]           tm_i;
  logic [CNT_WIDTH-1:0]         tnm_i;
  logic [IRQ_NUM-1:0]           irq_i;
  logic                         clam_i;
  logic                         comp_i;
  logic [IRQ_WIDTH-1:0]         id_i;
  logic [IRQ_NUM-1:0]           req_o;
  logic [IRQ_NUM-1:0]           busy_o;
  logic [IRQ_NUM*CNT_WIDTH-1:0] cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  int m_st  [IRQ_NUM];
  int m_cnt [IRQ_NUM];
  bit m_prev[IRQ_NUM];
  bit m_s1  [IRQ_NUM];
  bit m_s2  [IRQ_NUM];

  always #5 clk = ~clk;

  plic_gateway #(
    .IRQ_NUM  (IRQ_NUM),
    .IRQ_WIDTH(IRQ_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n_i),
    .en_i   (en_i),
    .tm_i   (tm_i),
    .tnm_i  (tnm_i),
    .irq_i  (irq_i),
    .clam_i (clam_i),
    .comp_i (comp_i),
    .id_i   (id_i),
    .req_o  (req_o),
    .busy_o (busy_o),
    .cnt_o  (cnt_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IRQ_NUM-1:0] exp_req();
    logic [IRQ_NUM-1:0] v = '0;
    for (int i = 0; i < IRQ_NUM; i++) v[i] = (m_st[i] == S_PEND);
    return v;
  endfunction

  function automatic logic [IRQ_NUM-1:0] exp_busy();
    logic [IRQ_NUM-1:0] v = '0;
    for (int i = 0; i < IRQ_NUM; i++) v[i] = (m_st[i] == S_BUSY);
    return v;
  endfunction

  function automatic logic [IRQ_NUM*CNT_WIDTH-1:0] exp_cnt();
    logic [IRQ_NUM*CNT_WIDTH-1:0] v = '0;
    for (int i = 0; i < IRQ_NUM; i++) v[i*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(m_cnt[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < IRQ_NUM; i++) begin
      m_st[i] = S_IDLE; m_cnt[i] = 0; m_prev[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
    end
  endtask

  // One clock of the gateway rules, using the inputs present at the edge.
  task automatic model_step();
    bit s[IRQ_NUM];
    int lim;
    lim = (tnm_i == 0) ? 1 : int'(tnm_i);
    for (int i = 0; i < IRQ_NUM; i++) begin
`ifdef PLIC_GATEWAY_SYNC_EN
      s[i] = m_s2[i];
`else
      s[i] = irq_i[i];
`endif
    end
    for (int i = 1; i < IRQ_NUM; i++) begin
      bit rise, mine;
      int nst, nc;
      rise = s[i] && !m_prev[i];
      mine = (int'(id_i) == i);
      nst  = m_st[i];
      nc   = m_cnt[i];
      if (m_st[i] == S_IDLE) begin
        if (en_i && (tm_i[i] ? (rise || m_cnt[i] > 0) : s[i])) begin
          nst = S_PEND;
          if (tm_i[i] && !rise) nc = m_cnt[i] - 1;
        end
      end else begin
        if (tm_i[i] && rise && en_i && m_cnt[i] < lim) nc = m_cnt[i] + 1;
        if (m_st[i] == S_PEND && clam_i && mine) nst = S_BUSY;
        else if (m_st[i] == S_BUSY && comp_i && mine) nst = S_IDLE;
      end
      if (!tm_i[i]) nc = 0;
      m_st[i]  = nst;
      m_cnt[i] = nc;
    end
    for (int i = 0; i < IRQ_NUM; i++) begin
      m_prev[i] = s[i];
      m_s2[i]   = m_s1[i];
      m_s1[i]   = irq_i[i];
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("req", 128'(req_o), 128'(exp_req()));
    check("busy", 128'(busy_o), 128'(exp_busy()));
    check("cnt", 128'(cnt_o), 128'(exp_cnt()));
  endtask

  task automatic strobe(input bit cl, input bit co, input int id);
    clam_i = cl;
    comp_i = co;
    id_i   = IRQ_WIDTH'(id);
    cycle();
    clam_i = 0;
    comp_i = 0;
    id_i   = '0;
  endtask

  task automatic pulse(input int src);
    irq_i[src] = 1'b1;
    cycle();
    irq_i[src] = 1'b0;
    cycle();
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n_i = 1'b0;
    #1;
    model_reset();
    check({tag, "_req"}, 128'(req_o), 128'(0));
    check({tag, "_busy"}, 128'(busy_o), 128'(0));
    check({tag, "_cnt"}, 128'(cnt_o), 128'(0));
    @(negedge clk);
    rst_n_i = 1'b1;
  endtask

  initial begin
    int lat;
    int exp_lat;
    int pick_q[$];
    rst_n_i = 1'b0; en_i = 1'b0; tm_i = '0; tnm_i = '0; irq_i = '0;
    clam_i = 1'b0; comp_i = 1'b0; id_i = '0;
    model_reset();
    #12;
    check("reset_req", 128'(req_o), 128'(0));
    check("reset_busy", 128'(busy_o), 128'(0));
    check("reset_cnt", 128'(cnt_o), 128'(0));
    @(negedge clk);
    rst_n_i = 1'b1;
    cycle();

    // Level source 3: request, claim, complete with line held high.
    en_i = 1'b1;
    irq_i[3] = 1'b1;
    cycle();
`ifndef PLIC_GATEWAY_SYNC_EN
    check("t1_req_up", 128'(req_o[3]), 128'(1));
`else
    cycle(); cycle();
`endif
    strobe(1, 0, 3);
    check("t1_claim_busy", 128'({req_o[3], busy_o[3]}), 128'(2'b01));
    strobe(0, 1, 3);
    check("t1_idle_gap", 128'({req_o[3], busy_o[3]}), 128'(2'b00));
    cycle();
    check("t1_rereq", 128'(req_o[3]), 128'(1));
    strobe(1, 0, 3);
    irq_i[3] = 1'b0;
    strobe(0, 1, 3);

    // Edge source 5: burst of pulses while busy saturates at the limit.
    tnm_i = 4'd3;
    tm_i[5] = 1'b1;
    pulse(5);
    strobe(1, 0, 5);
    for (int k = 0; k < 5; k++) pulse(5);
    check("t2_sat", 128'(cnt_o[5*CNT_WIDTH +: CNT_WIDTH]), 128'(3));
    for (int k = 0; k < 3; k++) begin
      strobe(0, 1, 5);
      cycle();
      check("t2_rereq", 128'(req_o[5]), 128'(1));
      strobe(1, 0, 5);
    end
    strobe(0, 1, 5);
    cycle(); cycle();
    check("t2_drained", 128'({req_o[5], cnt_o[5*CNT_WIDTH +: CNT_WIDTH]}), 128'(0));

    // Misuse: stray claims/completes, id 0.
    strobe(1, 0, 7);
    check("t3_claim_idle", 128'(busy_o[7]), 128'(0));
    irq_i[2] = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    strobe(0, 1, 2);
    check("t3_comp_pend", 128'(req_o[2]), 128'(1));
    strobe(1, 0, 0);
    strobe(0, 1, 0);
    irq_i[2] = 1'b0;
    strobe(1, 0, 2);
    strobe(0, 1, 2);

    // Same-cycle claim and complete while pending.
    irq_i[4] = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    irq_i[4] = 1'b0;
    strobe(1, 1, 4);
    check("t4_both", 128'(busy_o[4]), 128'(1));
    strobe(0, 1, 4);
    check("t4_done", 128'({req_o[4], busy_o[4]}), 128'(0));

    // Global disable blocks new requests but pending sources still claim.
    irq_i[10] = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    irq_i[10] = 1'b0;
    en_i = 1'b0;
    tm_i[6] = 1'b1;
    irq_i[8] = 1'b1;
    pulse(6);
    for (int k = 0; k < 3; k++) cycle();
    check("t5_blocked", 128'({req_o[6], req_o[8], cnt_o[6*CNT_WIDTH +: CNT_WIDTH]}), 128'(0));
    strobe(1, 0, 10);
    check("t5_claim", 128'(busy_o[10]), 128'(1));
    irq_i[8] = 1'b0;
    cycle(); cycle();
    en_i = 1'b1;
    strobe(0, 1, 10);

    // Asynchronous reset with source 9 busy and two buffered edges.
    tm_i[9] = 1'b1;
    pulse(9);
    strobe(1, 0, 9);
    pulse(9); pulse(9);
    check("t6_cnt2", 128'({busy_o[9], cnt_o[9*CNT_WIDTH +: CNT_WIDTH]}), 128'({1'b1, 4'd2}));
    async_reset("t6");
    cycle();

    // Level request latency.
`ifdef PLIC_GATEWAY_SYNC_EN
    exp_lat = 3;
`else
    exp_lat = 1;
`endif
    tm_i[11] = 1'b0;
    irq_i[11] = 1'b1;
    lat = 0;
    while (lat < 10 && !req_o[11]) begin
      cycle();
      lat++;
    end
    check("latency", 128'(lat), 128'(exp_lat));
    irq_i[11] = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    strobe(1, 0, 11);
    strobe(0, 1, 11);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      irq_i = $urandom() & $urandom();
      if ($urandom_range(0, 49) == 0) tm_i = $urandom();
      if ($urandom_range(0, 99) == 0) tnm_i = CNT_WIDTH'($urandom());
      en_i   = ($urandom_range(0, 9) != 0);
      clam_i = ($urandom_range(0, 2) == 0);
      comp_i = ($urandom_range(0, 2) == 0);
      pick_q.delete();
      for (int i = 0; i < IRQ_NUM; i++)
        if ((clam_i && m_st[i] == S_PEND) || (comp_i && m_st[i] == S_BUSY)) pick_q.push_back(i);
      if (pick_q.size() > 0 && $urandom_range(0, 3) != 0)
        id_i = IRQ_WIDTH'(pick_q[$urandom_range(0, pick_q.size() - 1)]);
      else
        id_i = IRQ_WIDTH'($urandom());
      if (n == 750) begin
        async_reset("rand_rst");
      end
      cycle();
    end
    clam_i = 0; comp_i = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
